metric_tracker: RTL and testbench

- Streaming, pipelined successor to the single-pair metric unit; parametrised in width and chunking.
- Per accepted candidate: computes the number of leading (MSB-first) matching bits between candidate hash a_i and target b_i, and tags the result.
- Tracks the running best candidate (metric and tag), flags threshold hits and counts processed candidates.
- Sits between the SHA-1 core output and the host result interface.

---
 rtl/metric_tracker_if.sv | 43 ++++
 rtl/metric_tracker.sv | 155 +++++++++++++++
 tb/tb_metric_tracker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/metric_tracker_if.sv
// Candidate stream in / metric and best-tracking results out, for metric_tracker.
// Revision 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

interface metric_tracker_if #(
   parameter int W     = 160,
   parameter int TAG_W = 32,
   parameter int CNT_W = 48
);
   localparam int MW = $clog2(W + 1);

   logic             in_valid_i;
   logic [W-1:0]     a_i;
   logic [W-1:0]     b_i;
   logic [TAG_W-1:0] tag_i;
   logic [MW-1:0]    threshold_i;
   logic             clear_i;

   logic             metric_valid_o;
   logic [MW-1:0]    metric_o;
   logic [TAG_W-1:0] metric_tag_o;
   logic             best_valid_o;
   logic [MW-1:0]    best_metric_o;
   logic [TAG_W-1:0] best_tag_o;
   logic             new_best_o;
   logic             hit_o;
   logic [CNT_W-1:0] count_o;

   modport slave (
      input  in_valid_i, a_i, b_i, tag_i, threshold_i, clear_i,
      output metric_valid_o, metric_o, metric_tag_o, best_valid_o,
             best_metric_o, best_tag_o, new_best_o, hit_o, count_o
   );

   modport master (
      output in_valid_i, a_i, b_i, tag_i, threshold_i, clear_i,
      input  metric_valid_o, metric_o, metric_tag_o, best_valid_o,
             best_metric_o, best_tag_o, new_best_o, hit_o, count_o
   );
endinterface

`default_nettype wire

// File: rtl/metric_tracker.sv
// metric_tracker: 3-stage leading-match-bits metric with running best, hit and count tracking.
// Revision 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module metric_tracker #(
   parameter int W     = 160,
   parameter int CHUNK = 16,
   parameter int TAG_W = 32,
   parameter int CNT_W = 48
) (
   input  logic clk_i,
   input  logic rst_i,
   metric_tracker_if.slave bus
);
   localparam int MW  = $clog2(W + 1);
   localparam int NCH = W / CHUNK;
   localparam int LZW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

   // ---------------- Stage 1: per-chunk leading-zero count ----------------
   logic [W-1:0]              diff;
   logic [NCH-1:0]            s1_zero_d;
   logic [NCH-1:0][LZW-1:0]   s1_lzc_d;
   logic                      s1_valid_q;
   logic [NCH-1:0]            s1_zero_q;
   logic [NCH-1:0][LZW-1:0]   s1_lzc_q;
   logic [TAG_W-1:0]          s1_tag_q;

   assign diff = bus.a_i ^ bus.b_i;

   // Chunk index 0 is the most significant chunk of diff.
   for (genvar gc = 0; gc < NCH; gc++) begin : g_chunk
      logic [CHUNK-1:0] seg;
      logic [LZW-1:0]   lzc;

      assign seg = diff[W-1-gc*CHUNK -: CHUNK];

      always_comb begin
         lzc = '0;
         for (int i = 0; i < CHUNK; i++) begin
            if (seg[i]) begin
               lzc = LZW'(CHUNK - 1 - i);
            end
         end
      end

      assign s1_lzc_d[gc]  = lzc;
      assign s1_zero_d[gc] = (seg == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_zero_q  <= '0;
         s1_lzc_q   <= '0;
         s1_tag_q   <= '0;
      end else begin
         s1_valid_q <= bus.in_valid_i;
         if (bus.in_valid_i) begin
            s1_zero_q <= s1_zero_d;
            s1_lzc_q  <= s1_lzc_d;
            s1_tag_q  <= bus.tag_i;
         end
      end
   end

   // ---------------- Stage 2: combine chunks into the metric ----------------
   logic [MW-1:0]    metric_d;
   logic             s2_found;
   logic             metric_valid_q;
   logic [MW-1:0]    metric_q;
   logic [TAG_W-1:0] metric_tag_q;

   always_comb begin
      metric_d = MW'(W);
      s2_found = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (!s2_found && !s1_zero_q[c]) begin
            metric_d = MW'(c * CHUNK) + MW'(s1_lzc_q[c]);
            s2_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         metric_valid_q <= 1'b0;
         metric_q       <= '0;
         metric_tag_q   <= '0;
      end else begin
         metric_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            metric_q     <= metric_d;
            metric_tag_q <= s1_tag_q;
         end
      end
   end

   // ---------------- Stage 3: best tracking, hit and count ----------------
   logic             best_valid_q;
   logic [MW-1:0]    best_metric_q;
   logic [TAG_W-1:0] best_tag_q;
   logic             new_best_q;
   logic             hit_q;
   logic [CNT_W-1:0] count_q;
   logic             replace;

   // Strictly greater: on a tie the earlier candidate stays best.
   assign replace = !best_valid_q || (metric_q > best_metric_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         best_valid_q  <= 1'b0;
         best_metric_q <= '0;
         best_tag_q    <= '0;
         new_best_q    <= 1'b0;
         hit_q         <= 1'b0;
         count_q       <= '0;
      end else begin
         new_best_q <= 1'b0;
         hit_q      <= 1'b0;
         if (bus.clear_i) begin
            // The stage-3 candidate of this cycle is dropped entirely.
            best_valid_q  <= 1'b0;
            best_metric_q <= '0;
            best_tag_q    <= '0;
            count_q       <= '0;
         end else if (metric_valid_q) begin
            hit_q <= (metric_q >= bus.threshold_i);
            if (count_q != '1) begin
               count_q <= count_q + CNT_W'(1);
            end
            if (replace) begin
               best_valid_q  <= 1'b1;
               best_metric_q <= metric_q;
               best_tag_q    <= metric_tag_q;
               new_best_q    <= 1'b1;
            end
         end
      end
   end

   assign bus.metric_valid_o = metric_valid_q;
   assign bus.metric_o       = metric_q;
   assign bus.metric_tag_o   = metric_tag_q;
   assign bus.best_valid_o   = best_valid_q;
   assign bus.best_metric_o  = best_metric_q;
   assign bus.best_tag_o     = best_tag_q;
   assign bus.new_best_o     = new_best_q;
   assign bus.hit_o          = hit_q;
   assign bus.count_o        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_metric_tracker.sv
// Directed self-checking bench for metric_tracker (W=160 and W=8 configurations).
`timescale 1ns/1ps
`default_nettype none

module tb_metric_tracker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   metric_tracker_if #(.W(160), .TAG_W(32), .CNT_W(48)) bw ();
   metric_tracker_if #(.W(8),   .TAG_W(8),  .CNT_W(2))  bs ();

   metric_tracker #(.W(160), .CHUNK(16), .TAG_W(32), .CNT_W(48)) dut_w (
      .clk_i(clk), .rst_i(rst), .bus(bw)
   );
   metric_tracker #(.W(8), .CHUNK(4), .TAG_W(8), .CNT_W(2)) dut_s (
      .clk_i(clk), .rst_i(rst), .bus(bs)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [159:0] a, input logic [159:0] b, input logic [31:0] t);
      bw.in_valid_i = 1'b1;
      bw.a_i        = a;
      bw.b_i        = b;
      bw.tag_i      = t;
      tick();
   endtask

   task automatic idle();
      bw.in_valid_i = 1'b0;
      bs.in_valid_i = 1'b0;
      tick();
   endtask

   task automatic do_clear();
      bw.clear_i = 1'b1;
      idle();
      bw.clear_i = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mvalid"}, 64'(bw.metric_valid_o), 64'd0);
      chk({tag, "_metric"}, 64'(bw.metric_o),       64'd0);
      chk({tag, "_mtag"},   64'(bw.metric_tag_o),   64'd0);
      chk({tag, "_bvalid"}, 64'(bw.best_valid_o),   64'd0);
      chk({tag, "_bmetric"},64'(bw.best_metric_o),  64'd0);
      chk({tag, "_btag"},   64'(bw.best_tag_o),     64'd0);
      chk({tag, "_newbest"},64'(bw.new_best_o),     64'd0);
      chk({tag, "_hit"},    64'(bw.hit_o),          64'd0);
      chk({tag, "_count"},  64'(bw.count_o),        64'd0);
   endtask

   // Candidate whose diff against b=0 has its top set bit at W-1-m, i.e. metric m.
   function automatic logic [159:0] hot(input int m);
      logic [159:0] one;
      one = 160'd1;
      return one << (159 - m);
   endfunction

   initial begin
      logic [159:0] pat;
      logic [159:0] bd [5];
      int           bexp [5];
      int           sm  [5];
      logic [63:0]  snb [5];
      int           sbm [5];
      int           sbt [5];
      int           hm  [3];
      logic [63:0]  hexp [3];
      logic [7:0]   sa;

      bw.in_valid_i = 1'b0; bw.a_i = '0; bw.b_i = '0; bw.tag_i = '0;
      bw.threshold_i = 8'd200; bw.clear_i = 1'b0;
      bs.in_valid_i = 1'b0; bs.a_i = '0; bs.b_i = '0; bs.tag_i = '0;
      bs.threshold_i = 4'd15; bs.clear_i = 1'b0;

      // Reset state
      repeat (3) tick();
      chk_zero("reset");
      chk("reset_s_count", 64'(bs.count_o), 64'd0);
      rst = 1'b0;
      tick();

      // Metric boundaries with 2-cycle latency
      pat = {5{32'hDEADBEEF}};
      bd[0] = '0;              bexp[0] = 160;
      bd[1] = hot(0);          bexp[1] = 0;
      bd[2] = 160'd1;          bexp[2] = 159;
      bd[3] = 160'd1 << 144;   bexp[3] = 15;
      bd[4] = 160'd1 << 143;   bexp[4] = 16;
      for (int i = 0; i < 5; i++) begin
         put(pat ^ bd[i], pat, 32'hA0 + 32'(i));
         chk("bnd_lat1_valid", 64'(bw.metric_valid_o), 64'd0);
         idle();
         chk("bnd_lat2_valid", 64'(bw.metric_valid_o), 64'd1);
         chk("bnd_metric",     64'(bw.metric_o),       64'(bexp[i]));
         chk("bnd_tag",        64'(bw.metric_tag_o),   64'hA0 + 64'(i));
         idle();
         chk("bnd_lat3_valid", 64'(bw.metric_valid_o), 64'd0);
         chk("bnd_hold_metric",64'(bw.metric_o),       64'(bexp[i]));
      end
      idle();
      do_clear();
      chk("clr_bvalid", 64'(bw.best_valid_o), 64'd0);
      chk("clr_count",  64'(bw.count_o),      64'd0);

      // Back-to-back stream: metrics 5,9,9,3,12 with tags 1..5
      sm[0] = 5; sm[1] = 9; sm[2] = 9; sm[3] = 3; sm[4] = 12;
      snb[0] = 1; snb[1] = 1; snb[2] = 0; snb[3] = 0; snb[4] = 1;
      sbm[0] = 5; sbm[1] = 9; sbm[2] = 9; sbm[3] = 9; sbm[4] = 12;
      sbt[0] = 1; sbt[1] = 2; sbt[2] = 2; sbt[3] = 2; sbt[4] = 5;
      for (int i = 0; i < 7; i++) begin
         if (i < 5) put(hot(sm[i]), '0, 32'(i + 1));
         else       idle();
         if (i >= 2) begin
            chk("b2b_newbest", 64'(bw.new_best_o),    snb[i-2]);
            chk("b2b_bmetric", 64'(bw.best_metric_o), 64'(sbm[i-2]));
            chk("b2b_btag",    64'(bw.best_tag_o),    64'(sbt[i-2]));
            chk("b2b_hit",     64'(bw.hit_o),         64'd0);
            chk("b2b_count",   64'(bw.count_o),       64'(i - 1));
         end
      end
      idle();
      chk("b2b_final_newbest", 64'(bw.new_best_o),    64'd0);
      chk("b2b_final_bmetric", 64'(bw.best_metric_o), 64'd12);
      chk("b2b_final_btag",    64'(bw.best_tag_o),    64'd5);
      chk("b2b_final_count",   64'(bw.count_o),       64'd5);

      // Threshold 10 with metrics 9, 10, 160
      do_clear();
      bw.threshold_i = 8'd10;
      hm[0] = 9; hm[1] = 10; hm[2] = 160;
      hexp[0] = 0; hexp[1] = 1; hexp[2] = 1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) put((hm[i] == 160) ? 160'd0 : hot(hm[i]), '0, 32'h10 + 32'(i));
         else       idle();
         if (i >= 2) chk("thr_hit", 64'(bw.hit_o), hexp[i-2]);
      end
      idle();
      chk("thr_hit_after", 64'(bw.hit_o), 64'd0);

      // Clear while a metric-20 candidate is in stage 3, metric-4 one behind
      put(hot(20), '0, 32'h20);
      put(hot(4),  '0, 32'h21);
      chk("clr3_s3_valid", 64'(bw.metric_valid_o), 64'd1);
      do_clear();
      chk("clr3_newbest0", 64'(bw.new_best_o),   64'd0);
      chk("clr3_hit0",     64'(bw.hit_o),        64'd0);
      chk("clr3_count0",   64'(bw.count_o),      64'd0);
      chk("clr3_bvalid0",  64'(bw.best_valid_o), 64'd0);
      idle();
      chk("clr3_newbest1", 64'(bw.new_best_o),    64'd1);
      chk("clr3_bmetric",  64'(bw.best_metric_o), 64'd4);
      chk("clr3_btag",     64'(bw.best_tag_o),    64'h21);
      chk("clr3_bvalid1",  64'(bw.best_valid_o),  64'd1);
      chk("clr3_count1",   64'(bw.count_o),       64'd1);
      idle();
      chk("clr3_newbest2", 64'(bw.new_best_o), 64'd0);

      // Reset with two candidates in flight
      put(hot(50), '0, 32'h30);
      put(hot(60), '0, 32'h31);
      bw.in_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_fl_mvalid",  64'(bw.metric_valid_o), 64'd0);
         chk("rst_fl_newbest", 64'(bw.new_best_o),     64'd0);
         chk("rst_fl_hit",     64'(bw.hit_o),          64'd0);
         idle();
      end
      chk_zero("rst_fl");

      // W=8, CHUNK=4: sweep top differing bit, then equal inputs; count saturates at 3
      for (int i = 0; i < 10; i++) begin
         if (i < 9) begin
            bs.in_valid_i = 1'b1;
            bs.b_i        = 8'h5A;
            bs.tag_i      = 8'(i + 1);
            if (i < 8) begin
               sa = (8'd1 << i) | (((8'd1 << i) - 8'd1) & 8'h55);
               bs.a_i = 8'h5A ^ sa;
            end else begin
               bs.a_i = 8'h5A;
            end
            tick();
         end else begin
            idle();
         end
         if (i >= 1) begin
            chk("w8_valid",  64'(bs.metric_valid_o), 64'd1);
            chk("w8_metric", 64'(bs.metric_o), (i - 1 < 8) ? 64'(7 - (i - 1)) : 64'd8);
            chk("w8_tag",    64'(bs.metric_tag_o), 64'(i));
         end
      end
      idle();
      idle();
      chk("w8_count_sat", 64'(bs.count_o),       64'd3);
      chk("w8_bmetric",   64'(bs.best_metric_o), 64'd8);
      chk("w8_btag",      64'(bs.best_tag_o),    64'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
